// File: rtl/bitstream_reader.sv
// -----------------------------------------------------------------------------
// bitstream_reader
//
// Byte-to-bit front end for the arithmetic decoder. Bytes arrive over a
// valid/ready handshake and are packed MSB-first into a bit accumulator. The
// consumer pulls 1..MAX_BITS bits per request, right-justified, and may ask
// to skip to the next byte boundary. End of stream and reads past the end of
// the stream are reported.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    upstream byte
//   in_valid   in_data valid
//   in_last    in_data is the final byte of the stream (qualified by in_valid)
//   in_ready   byte accepted when in_valid && in_ready
//   rd_req     read request
//   rd_nbits   number of bits requested (1..MAX_BITS; other values ignored)
//   rd_ready   combinational: a read of rd_nbits can be served this cycle
//   rd_data    returned bits, right-justified, upper bits zero
//   rd_valid   one-cycle pulse, rd_data valid
//   align_req  drop buffered bits up to the next byte boundary
//   bit_cnt    number of buffered bits
//   eos        final byte accepted and buffer empty
//   underflow  sticky: a read went past the end of the stream
// -----------------------------------------------------------------------------
module bitstream_reader #(
    parameter int  ACC_W    = 32,
    parameter int  MAX_BITS = 16,
    localparam int NB_W     = $clog2(MAX_BITS + 1),
    localparam int CNT_W    = $clog2(ACC_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                rd_req,
    input  logic [NB_W-1:0]     rd_nbits,
    output logic                rd_ready,
    output logic [MAX_BITS-1:0] rd_data,
    output logic                rd_valid,
    input  logic                align_req,
    output logic [CNT_W-1:0]    bit_cnt,
    output logic                eos,
    output logic                underflow
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0]    acc_reg,       acc_next;
    logic [CNT_W-1:0]    cnt_reg,       cnt_next;
    logic                last_seen_reg, last_seen_next;
    logic [MAX_BITS-1:0] rd_data_reg,   rd_data_next;
    logic                rd_valid_reg,  rd_valid_next;
    logic                eos_reg,       eos_next;
    logic                underflow_reg, underflow_next;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic                n_ok;
    logic [CNT_W-1:0]    n_cnt;
    logic                have_bits;
    logic                rd_fire;
    logic                align_fire;
    logic                in_fire;
    logic [MAX_BITS-1:0] top_bits;
    logic [NB_W-1:0]     rd_shamt;
    logic [MAX_BITS-1:0] rd_bits;
    logic [ACC_W-1:0]    byte_word;
    logic [ACC_W-1:0]    acc_c;
    logic [CNT_W-1:0]    cnt_c;

    assign n_ok      = (rd_nbits != '0) && (rd_nbits <= NB_W'(MAX_BITS));
    assign n_cnt     = CNT_W'(rd_nbits);
    assign have_bits = (cnt_reg >= n_cnt);

    // Once the final byte is in, every read is served: a short buffer is
    // padded with zeros and flagged as underflow.
    assign rd_ready  = have_bits || last_seen_reg;

    // Depends on registered state only, so a same-cycle read never changes
    // whether the upstream byte is taken.
    assign in_ready  = !last_seen_reg && (cnt_reg <= CNT_W'(ACC_W - 8));

    assign rd_fire    = rd_req && n_ok && rd_ready;
    assign align_fire = align_req && !rd_req;
    assign in_fire    = in_valid && in_ready;

    // Bits below the valid region of acc are always zero, so the top n bits
    // already hold "remaining bits followed by zeros" in the underflow case.
    assign top_bits = acc_reg[ACC_W-1 -: MAX_BITS];
    assign rd_shamt = NB_W'(MAX_BITS) - rd_nbits;
    assign rd_bits  = top_bits >> rd_shamt;

    assign byte_word = {in_data, {(ACC_W - 8){1'b0}}};

    // -------------------------------------------------------------------------
    // Next-state logic: consume (read or align) first, then append the byte
    // directly below whatever survives the consume.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_c          = acc_reg;
        cnt_c          = cnt_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        last_seen_next = last_seen_reg;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        underflow_next = underflow_reg;
        eos_next       = eos_reg;

        if (rd_fire) begin
            rd_data_next  = rd_bits;
            rd_valid_next = 1'b1;
            if (have_bits) begin
                acc_c = acc_reg << rd_nbits;
                cnt_c = cnt_reg - n_cnt;
            end else begin
                acc_c          = '0;
                cnt_c          = '0;
                underflow_next = 1'b1;
            end
        end else if (align_fire) begin
            // Bytes are appended whole, so cnt mod 8 is exactly the number
            // of bits standing above the next byte boundary.
            acc_c = acc_reg << cnt_reg[2:0];
            cnt_c = cnt_reg - CNT_W'(cnt_reg[2:0]);
        end

        acc_next = acc_c;
        cnt_next = cnt_c;
        if (in_fire) begin
            acc_next = acc_c | (byte_word >> cnt_c);
            cnt_next = cnt_c + CNT_W'(8);
            if (in_last) begin
                last_seen_next = 1'b1;
            end
        end

        eos_next = last_seen_next && (cnt_next == '0);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            last_seen_reg <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            eos_reg       <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            last_seen_reg <= last_seen_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            eos_reg       <= eos_next;
            underflow_reg <= underflow_next;
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign bit_cnt   = cnt_reg;
    assign eos       = eos_reg;
    assign underflow = underflow_reg;

endmodule

// File: doc/bitstream_reader.md
# bitstream_reader

Synthesizable, parametrised bitstream front-end for the VVC arithmetic decoder. It accepts bytes from an upstream byte source over a valid/ready handshake and buffers them MSB-first in a bit accumulator. The CABAC decoder pulls 1..MAX_BITS bits per request, and can request byte alignment. It signals end-of-stream and underflow, replacing the simulation-only file feeder in synthesizable builds.

## Interface
- ACC_W, 32, accumulator width in bits; must be ≥ MAX_BITS+8.
- MAX_BITS, 16, maximum bits returned per read.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  upstream byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies final byte of stream; sampled with in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- rd_req  in  1  read request.
- rd_nbits  in  $clog2(MAX_BITS+1)  bits requested, n.
- rd_ready  out  1  combinational; read with current rd_nbits can be served this cycle.
- rd_data  out  MAX_BITS  returned bits, right-justified, upper bits zero.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- align_req  in  1  discard cnt mod 8 bits.
- bit_cnt  out  $clog2(ACC_W+1)  valid bits buffered (cnt).
- eos  out  1  last byte accepted and cnt==0.
- underflow  out  1  sticky; a read consumed past end of stream.

## Operation
- State: acc[ACC_W-1:0], cnt, last_seen. Bits held in acc[ACC_W-1 -: cnt]; the next bit to consume is acc MSB.
- in_ready = !last_seen && (ACC_W - cnt ≥ 8), computed from registered state only, so it is independent of same-cycle reads.
- Byte accept: in_data is placed immediately below the bits remaining after any same-cycle consume; cnt += 8. If in_last, then last_seen ← 1.
- Valid read: n in 1..MAX_BITS. n = 0 or n > MAX_BITS is ignored: no rd_valid, no state change.
- rd_ready = (cnt ≥ n) || last_seen.
- rd_req && rd_ready && cnt ≥ n:
  - rd_data ← top n bits.
  - acc shifts left by n; cnt -= n.
- rd_req && last_seen && cnt < n:
  - rd_data ← remaining cnt bits followed by (n−cnt) zeros, n-bit field right-justified.
  - cnt ← 0; underflow ← 1.
- align_req (no rd_req): drop cnt mod 8 MSBs; no-op when already aligned. Because bytes are appended whole, this lands on a byte boundary.
- rd_req && align_req in the same cycle: the read is served and align is ignored.
- eos = last_seen && cnt==0, registered.
- Reset value of every state element and output: acc=0, cnt=0, last_seen=0, rd_data=0, rd_valid=0, eos=0, underflow=0. in_ready=1 after reset.
- Widths: cnt arithmetic carries one extra bit; cnt never exceeds ACC_W.

## Timing
- Read latency is 1 cycle: the request is accepted on edge k; rd_data/rd_valid are valid after edge k, for one cycle.
- Back-to-back reads are allowed every cycle; each read sees the cnt left by the previous one.
- Same-cycle byte accept + read: cnt_next = cnt − n + 8. A byte accepted at edge k is readable from cycle k+1.
- A request with rd_ready=0 is not held or queued; the requester must retry.
- rst mid-stream discards all buffered bits and clears last_seen/underflow/eos on the next edge. Any pending rd_valid is suppressed.
- Full (cnt > ACC_W−8): in_ready=0 until reads free ≥ 8 bits.
- Empty (cnt=0, !last_seen): rd_ready=0 for every valid n.

## Test plan
- Bytes 0xA5,0x3C, then read 4, 8, 4 → rd_data 0xA, 0x53, 0xC; bit_cnt ends at 0, eos=0.
- Bytes 0xF0,0x81; read 3 → 0x7; align_req; read 8 → 0x81. An align issued when bit_cnt=8 drops nothing.
- Feed 0x11,0x22,0x33,0x44 with no reads:
  - in_ready=1 through the 4th byte (cnt 24 → 32), then 0.
  - Read 16 → 0x1122 and bit_cnt=16; in_ready=1 the following cycle.
- cnt=16, in_valid with 0x55 and read 16 in the same cycle → rd_data = top 16 bits, bit_cnt=8; next read 8 → 0x55.
- Byte 0xFF with in_last, then read 10 → rd_data=0x3FC, underflow=1, eos=1 next cycle. A subsequent read 4 → 0x0.
- Assert rst while bit_cnt=20 and a read is in flight → next cycle all outputs at reset values, in_ready=1; the stream restarts cleanly.
